ex_stage_unit: RTL
==================

// Module: ex_stage_unit
// PURPOSE
//  Execute stage of the RISC-TOY 5-stage pipeline. Reads the ID/EX register outputs and forwards operands
//  from EX/MEM and MEM/WB. Computes the ALU result, memory address, store data and branch outcome.
//  Registers all of these into the EX/MEM register, with stall and flush. Also drives the load-use stall to decode.
// PARAMETERS
//  XLEN      32  datapath width
//  ZERO_REG  31  base-register index that reads as 0 for LD/ST address calculation
// PORTS
//  CLK             in   1   clock, all state on posedge
//  RST             in   1   reset, synchronous, active-high
//  PC_in           in   32  PC of EX instruction (from ID/EX)
//  OpCode_in       in   5   opcode
//  IMM_in          in   22  raw immediate field
//  ImmSel1_in      in   2   00 sext IMM[16:0], 01 zext IMM[16:0], 10 sext IMM[21:0], 11 zext IMM[4:0] (shamt)
//  MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in  in 1 each  control from ID/EX
//  Addr1_data_in   in   32  rb value from regfile;  Addr2_data_in in 32  rc value (ra value for ST/STR)
//  Write_Addr_in, Read_Addr1_in, Read_Addr2_in  in 5 each  ra / rb / rc(or ra) indices
//  ID_Read_Addr1, ID_Read_Addr2  in 5  source indices of the instruction currently in ID
//  WB_RegWrite     in   1   MEM/WB write enable;  WB_Write_Addr in 5;  WB_Data in 32
//  MEM_Stall       in   1   downstream hold request
//  Flush           in   1   kill EX instruction (taken branch resolved)
//  LoadUse_Stall   out  1   combinational, to decode/ID-EX
//  ALU_Result_out, Store_Data_out  out 32  EX/MEM registered;  Write_Addr_out out 5
//  RegWrite_out, MemRead_out, MemWrite_out, MemtoReg_out, Valid_out  out 1  EX/MEM registered
//  Branch_Taken_out out 1; Branch_Target_out out 32  EX/MEM registered
// BEHAVIOUR
//  - Reset: every registered output = 0 at first posedge with RST=1.
//  - Latency 1 cycle: EX inputs at edge N appear on *_out after edge N.
//  - Register priority per edge: RST > Flush (control bits, Valid_out and Branch_Taken_out = 0, data = 0) > MEM_Stall (hold all) > load.
//  - Forwarding per operand index X:
//    * EX/MEM hit (RegWrite_out & ~MemRead_out & Valid_out & Write_Addr_out==X) beats WB hit (WB_RegWrite & WB_Write_Addr==X).
//    * Otherwise regfile data is used. Index 0 is not special.
//  - LoadUse_Stall = MemRead_in & RegWrite_in & (Write_Addr_in==ID_Read_Addr1 | Write_Addr_in==ID_Read_Addr2).
//  - Immediate per ImmSel1_in; all arithmetic is mod 2^32, carry/overflow discarded.
//  - ALU, A=fwd rb, B=fwd rc, I=imm:
//    * ADDI/ANDI/ORI: A op I.  MOVI: I.  ADD/SUB/AND/OR/XOR: A op B.  NEG: -B.  NOT: ~B.
//    * LSR/ASR/SHL/ROR: A shifted by sh; sh = I[4:0] if ImmSel1_in==11, else B[4:0].
//    * sh=0 returns A. ROR wraps.
//  - LD/ST: addr = (Read_Addr1_in==ZERO_REG ? 0 : A) + I.  LDR/STR: PC_in+4+I.
//    Store_Data_out = fwd Addr2 value.
//  - Branch conditions: BR/BRL cond = IMM_in[2:0] on B; 0 never, 1 always, 2 B==0, 3 B!=0, 4 B>=0 signed, 5 B<0, 6-7 never.
//  - BR/BRL: target = A. J/JL: always taken, target = PC_in+4+I.
//    BRL/JL: ALU_Result_out = PC_in+4; link write follows RegWrite_in.
//  - Undefined opcodes: result 0; controls pass through unchanged.
//  - Stall and Flush both high: Flush wins.
//  - Flush does not gate LoadUse_Stall.
//  - RST mid-stall clears the held contents.
// STRUCTURE
//  - Package rt_pkg: opcode localparams (ADDI=0 .. STR=22), ImmSel codes, branch-cond codes, XLEN.
//  - Sub-module rt_fwd_mux: one instance per operand; pure combinational priority select.
//  - EX/MEM register stays inline in this module.
// TESTING
//  - Reset: RST=1 for 2 cycles with junk inputs -> all *_out = 0, Valid_out=0.
//  - ADD r1 then ADD r2,r1,r1: A=5 via EX/MEM forward -> ALU_Result_out=10, even though regfile data=0.
//  - LD r3 in EX, ID reads r3 -> LoadUse_Stall=1 same cycle. ID reads r4 -> LoadUse_Stall=0.
//  - LD rb=31, I=0x10, A=0xFFFF -> ALU_Result_out=0x10.
//    ROR A=0x00000001 sh=1 -> 0x80000000. ADDI 0xFFFFFFFF+1 -> 0.
//  - BR cond=2, B=0, A=0x40 -> Branch_Taken_out=1, target 0x40.
//    Flush next cycle -> Valid_out=0, RegWrite_out=0.
//  - MEM_Stall=1 for 3 cycles with changing inputs -> outputs frozen.
//    Flush+MEM_Stall together -> controls cleared.

Source files
------------

// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - RISC-TOY opcode, immediate-select and branch-condition definitions
package rt_pkg;

    localparam int RT_XLEN = 32;

    localparam logic [4:0] OP_ADDI = 5'd0;
    localparam logic [4:0] OP_ANDI = 5'd1;
    localparam logic [4:0] OP_ORI  = 5'd2;
    localparam logic [4:0] OP_MOVI = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_NEG  = 5'd6;
    localparam logic [4:0] OP_NOT  = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_SHL  = 5'd13;
    localparam logic [4:0] OP_ROR  = 5'd14;
    localparam logic [4:0] OP_BR   = 5'd15;
    localparam logic [4:0] OP_BRL  = 5'd16;
    localparam logic [4:0] OP_J    = 5'd17;
    localparam logic [4:0] OP_JL   = 5'd18;
    localparam logic [4:0] OP_LD   = 5'd19;
    localparam logic [4:0] OP_ST   = 5'd20;
    localparam logic [4:0] OP_LDR  = 5'd21;
    localparam logic [4:0] OP_STR  = 5'd22;

    localparam logic [1:0] IMM_SEXT17 = 2'b00;
    localparam logic [1:0] IMM_ZEXT17 = 2'b01;
    localparam logic [1:0] IMM_SEXT22 = 2'b10;
    localparam logic [1:0] IMM_SHAMT  = 2'b11;

    localparam logic [2:0] BC_NEVER   = 3'd0;
    localparam logic [2:0] BC_ALWAYS  = 3'd1;
    localparam logic [2:0] BC_ZERO    = 3'd2;
    localparam logic [2:0] BC_NONZERO = 3'd3;
    localparam logic [2:0] BC_GEZ     = 3'd4;
    localparam logic [2:0] BC_LTZ     = 3'd5;

    // Codes 6 and 7 are reserved and never take the branch.
    function automatic logic branch_cond_met(input logic [2:0] cond,
                                             input logic       is_zero,
                                             input logic       is_neg);
        logic met;
        met = 1'b0;
        case (cond)
            BC_NEVER:   met = 1'b0;
            BC_ALWAYS:  met = 1'b1;
            BC_ZERO:    met = is_zero;
            BC_NONZERO: met = ~is_zero;
            BC_GEZ:     met = ~is_neg;
            BC_LTZ:     met = is_neg;
            default:    met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/ex_stage_unit_if.sv
// rtl/ex_stage_unit_if.sv - ID/EX inputs, forwarding sources and EX/MEM outputs of the execute stage
interface ex_stage_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] PC_in;
    logic [4:0]      OpCode_in;
    logic [21:0]     IMM_in;
    logic [1:0]      ImmSel1_in;
    logic            MemRead_in;
    logic            MemWrite_in;
    logic            RegWrite_in;
    logic            MemtoReg_in;
    logic [XLEN-1:0] Addr1_data_in;
    logic [XLEN-1:0] Addr2_data_in;
    logic [4:0]      Write_Addr_in;
    logic [4:0]      Read_Addr1_in;
    logic [4:0]      Read_Addr2_in;
    logic [4:0]      ID_Read_Addr1;
    logic [4:0]      ID_Read_Addr2;
    logic            WB_RegWrite;
    logic [4:0]      WB_Write_Addr;
    logic [XLEN-1:0] WB_Data;
    logic            MEM_Stall;
    logic            Flush;

    logic            LoadUse_Stall;
    logic [XLEN-1:0] ALU_Result_out;
    logic [XLEN-1:0] Store_Data_out;
    logic [4:0]      Write_Addr_out;
    logic            RegWrite_out;
    logic            MemRead_out;
    logic            MemWrite_out;
    logic            MemtoReg_out;
    logic            Valid_out;
    logic            Branch_Taken_out;
    logic [XLEN-1:0] Branch_Target_out;

    modport master (
        output PC_in, OpCode_in, IMM_in, ImmSel1_in,
        output MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in,
        output Addr1_data_in, Addr2_data_in, Write_Addr_in, Read_Addr1_in, Read_Addr2_in,
        output ID_Read_Addr1, ID_Read_Addr2,
        output WB_RegWrite, WB_Write_Addr, WB_Data, MEM_Stall, Flush,
        input  LoadUse_Stall, ALU_Result_out, Store_Data_out, Write_Addr_out,
        input  RegWrite_out, MemRead_out, MemWrite_out, MemtoReg_out, Valid_out,
        input  Branch_Taken_out, Branch_Target_out
    );

    modport slave (
        input  PC_in, OpCode_in, IMM_in, ImmSel1_in,
        input  MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in,
        input  Addr1_data_in, Addr2_data_in, Write_Addr_in, Read_Addr1_in, Read_Addr2_in,
        input  ID_Read_Addr1, ID_Read_Addr2,
        input  WB_RegWrite, WB_Write_Addr, WB_Data, MEM_Stall, Flush,
        output LoadUse_Stall, ALU_Result_out, Store_Data_out, Write_Addr_out,
        output RegWrite_out, MemRead_out, MemWrite_out, MemtoReg_out, Valid_out,
        output Branch_Taken_out, Branch_Target_out
    );
endinterface

// File: rtl/rt_fwd_mux.sv
// rtl/rt_fwd_mux.sv - operand forwarding select: EX/MEM result, then MEM/WB data, then regfile
module rt_fwd_mux #(
    parameter int XLEN = rt_pkg::RT_XLEN
) (
    input  logic [4:0]      src_addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            exm_fwd_en,
    input  logic [4:0]      exm_addr,
    input  logic [XLEN-1:0] exm_data,
    input  logic            wb_fwd_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

    // Register 0 is an ordinary register here, so no index is excluded from matching.
    always_comb begin
        fwd_data = rf_data;
        if (exm_fwd_en && (exm_addr == src_addr)) begin
            fwd_data = exm_data;
        end else if (wb_fwd_en && (wb_addr == src_addr)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/ex_stage_unit.sv
// rtl/ex_stage_unit.sv - RISC-TOY execute stage: forwarding, ALU, address/branch resolve, EX/MEM register
module ex_stage_unit
    import rt_pkg::*;
#(
    parameter int         XLEN     = RT_XLEN,
    parameter logic [4:0] ZERO_REG = 5'd31
) (
    input logic            CLK,
    input logic            RST,
    ex_stage_unit_if.slave bus
);

    logic            exm_fwd_en;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] ldst_base;
    logic [XLEN-1:0] ror_res;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] br_target;
    logic            br_taken;
    logic [4:0]      sh;
    logic [5:0]      ror_lsh;

    // A load sitting in EX/MEM has no data yet; decode stalls for that case instead.
    assign exm_fwd_en = bus.RegWrite_out & ~bus.MemRead_out & bus.Valid_out;

    rt_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
        .src_addr   (bus.Read_Addr1_in),
        .rf_data    (bus.Addr1_data_in),
        .exm_fwd_en (exm_fwd_en),
        .exm_addr   (bus.Write_Addr_out),
        .exm_data   (bus.ALU_Result_out),
        .wb_fwd_en  (bus.WB_RegWrite),
        .wb_addr    (bus.WB_Write_Addr),
        .wb_data    (bus.WB_Data),
        .fwd_data   (op_a)
    );

    rt_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
        .src_addr   (bus.Read_Addr2_in),
        .rf_data    (bus.Addr2_data_in),
        .exm_fwd_en (exm_fwd_en),
        .exm_addr   (bus.Write_Addr_out),
        .exm_data   (bus.ALU_Result_out),
        .wb_fwd_en  (bus.WB_RegWrite),
        .wb_addr    (bus.WB_Write_Addr),
        .wb_data    (bus.WB_Data),
        .fwd_data   (op_b)
    );

    // Not gated by Flush: the decode-side hold must still see a pending load.
    assign bus.LoadUse_Stall = bus.MemRead_in & bus.RegWrite_in &
                               ((bus.Write_Addr_in == bus.ID_Read_Addr1) |
                                (bus.Write_Addr_in == bus.ID_Read_Addr2));

    always_comb begin
        imm = '0;
        case (bus.ImmSel1_in)
            IMM_SEXT17: imm = {{(XLEN-17){bus.IMM_in[16]}}, bus.IMM_in[16:0]};
            IMM_ZEXT17: imm = {{(XLEN-17){1'b0}}, bus.IMM_in[16:0]};
            IMM_SEXT22: imm = {{(XLEN-22){bus.IMM_in[21]}}, bus.IMM_in};
            IMM_SHAMT:  imm = {{(XLEN-5){1'b0}}, bus.IMM_in[4:0]};
            default:    imm = '0;
        endcase
    end

    assign pc_plus4  = bus.PC_in + XLEN'(4);
    assign sh        = (bus.ImmSel1_in == IMM_SHAMT) ? imm[4:0] : op_b[4:0];
    assign ldst_base = (bus.Read_Addr1_in == ZERO_REG) ? '0 : op_a;

    // With sh = 0 the left term shifts out completely and the rotate returns A.
    assign ror_lsh = 6'(XLEN) - {1'b0, sh};
    assign ror_res = (op_a >> sh) | (op_a << ror_lsh);

    always_comb begin
        alu_res   = '0;
        br_taken  = 1'b0;
        br_target = '0;
        case (bus.OpCode_in)
            OP_ADDI: alu_res = op_a + imm;
            OP_ANDI: alu_res = op_a & imm;
            OP_ORI:  alu_res = op_a | imm;
            OP_MOVI: alu_res = imm;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_NEG:  alu_res = '0 - op_b;
            OP_NOT:  alu_res = ~op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_LSR:  alu_res = op_a >> sh;
            OP_ASR:  alu_res = $unsigned($signed(op_a) >>> sh);
            OP_SHL:  alu_res = op_a << sh;
            OP_ROR:  alu_res = ror_res;
            OP_BR: begin
                br_taken  = branch_cond_met(bus.IMM_in[2:0], op_b == '0, op_b[XLEN-1]);
                br_target = op_a;
            end
            OP_BRL: begin
                br_taken  = branch_cond_met(bus.IMM_in[2:0], op_b == '0, op_b[XLEN-1]);
                br_target = op_a;
                alu_res   = pc_plus4;
            end
            OP_J: begin
                br_taken  = 1'b1;
                br_target = pc_plus4 + imm;
            end
            OP_JL: begin
                br_taken  = 1'b1;
                br_target = pc_plus4 + imm;
                alu_res   = pc_plus4;
            end
            OP_LD, OP_ST:   alu_res = ldst_base + imm;
            OP_LDR, OP_STR: alu_res = pc_plus4 + imm;
            default:        alu_res = '0;
        endcase
    end

    // Reset and flush both empty the slot; a stall holds it unchanged.
    always_ff @(posedge CLK) begin
        if (RST || bus.Flush) begin
            bus.ALU_Result_out    <= '0;
            bus.Store_Data_out    <= '0;
            bus.Write_Addr_out    <= '0;
            bus.RegWrite_out      <= 1'b0;
            bus.MemRead_out       <= 1'b0;
            bus.MemWrite_out      <= 1'b0;
            bus.MemtoReg_out      <= 1'b0;
            bus.Valid_out         <= 1'b0;
            bus.Branch_Taken_out  <= 1'b0;
            bus.Branch_Target_out <= '0;
        end else if (!bus.MEM_Stall) begin
            bus.ALU_Result_out    <= alu_res;
            bus.Store_Data_out    <= op_b;
            bus.Write_Addr_out    <= bus.Write_Addr_in;
            bus.RegWrite_out      <= bus.RegWrite_in;
            bus.MemRead_out       <= bus.MemRead_in;
            bus.MemWrite_out      <= bus.MemWrite_in;
            bus.MemtoReg_out      <= bus.MemtoReg_in;
            bus.Valid_out         <= 1'b1;
            bus.Branch_Taken_out  <= br_taken;
            bus.Branch_Target_out <= br_target;
        end
    end

endmodule
